// File: rtl/lock_key_loader.sv
// Key-load controller for the key-locked c432 core.
// Fetches a serial key with even parity, retries, then locks it in.
module lock_key_loader #(
    parameter int KEY_W     = 5,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           kd_req,
    input  logic                           kd_valid,
    input  logic                           kd_bit,
    output logic [KEY_W-1:0]               key,
    output logic                           key_valid,
    output logic                           busy,
    output logic                           error,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_RETRY  = 3'd3;
    localparam logic [2:0] S_LOADED = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             parity_q, parity_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             kd_req_q, kd_req_d;
    logic             busy_q, busy_d;
    logic             error_q, error_d;
    logic             fail;

    // Next-state logic: serial capture, parity check, retry accounting.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        parity_d = parity_q;
        retry_d  = retry_q;
        key_d    = key_q;
        fail     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_REQ;
                    shadow_d = '0;
                    cnt_d    = '0;
                    timer_d  = '0;
                end
            end
            S_REQ: begin
                if (kd_valid) begin
                    timer_d = '0;
                    if (cnt_q < CNT_W'(KEY_W)) begin
                        shadow_d = {shadow_q[KEY_W-2:0], kd_bit};
                        cnt_d    = cnt_q + 1'b1;
                    end else begin
                        parity_d = kd_bit;
                        state_d  = S_CHECK;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    fail = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CHECK: begin
                if ((^shadow_q ^ parity_q) == 1'b0) begin
                    state_d = S_LOADED;
                    key_d   = shadow_q;
                end else begin
                    fail = 1'b1;
                end
            end
            S_RETRY: begin
                shadow_d = '0;
                cnt_d    = '0;
                timer_d  = '0;
                state_d  = S_REQ;
            end
            S_LOADED: state_d = S_LOADED;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase

        if (fail) begin
            retry_d = retry_q + 1'b1;
            if (retry_d == RTY_W'(MAX_RETRY)) begin
                state_d = S_ERROR;
            end else begin
                state_d = S_RETRY;
            end
        end
    end

    // Outputs are decoded from the next state so they register cleanly.
    always_comb begin
        kd_req_d    = (state_d == S_REQ);
        busy_d      = (state_d == S_REQ) || (state_d == S_CHECK) ||
                      (state_d == S_RETRY);
        key_valid_d = (state_d == S_LOADED);
        error_d     = (state_d == S_ERROR);
    end

    // State and output registers with asynchronous abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            parity_q    <= 1'b0;
            retry_q     <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            kd_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            parity_q    <= parity_d;
            retry_q     <= retry_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            kd_req_q    <= kd_req_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign kd_req    = kd_req_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign error     = error_q;
    assign retry_cnt = retry_q;

endmodule
